regfile_wb_arbiter: RTL

- Sole owner of the register file's single write port (RegWrite / Write_Reg_Num / Write_Data).
- After reset, sequences an initialisation sweep that writes INIT_VALUE to every register.
- Then round-robin arbitrates two writeback requesters (req0: ALU writeback; req1: load/memory writeback) over valid/ready handshakes.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: init sweep after reset, then
// round-robin arbitration of ALU and load writeback requesters.
module regfile_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter int ZERO_REG_PROTECT = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              init_req,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_Reg_Num,
  output logic [DATA_W-1:0] Write_Data,
  output logic              init_busy,
  output logic              grant_id
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam bit PROTECT = (ZERO_REG_PROTECT != 0);

  state_t state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic last_q, last_d;
  logic we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic gid_d;
  logic rdy0, rdy1;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= INIT;
      cnt_q <= '0;
      last_q <= 1'b1;
      RegWrite <= 1'b0;
      Write_Reg_Num <= '0;
      Write_Data <= '0;
      grant_id <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      RegWrite <= we_d;
      Write_Reg_Num <= addr_d;
      Write_Data <= data_d;
      grant_id <= gid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    we_d = 1'b0;
    addr_d = Write_Reg_Num;
    data_d = Write_Data;
    gid_d = grant_id;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    win_addr = req0_addr;
    win_data = req0_data;
    unique case (state_q)
      INIT: begin
        we_d = 1'b1;
        addr_d = cnt_q[ADDR_W-1:0];
        data_d = INIT_VALUE;
        gid_d = 1'b0;
        if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      RUN: begin
        if (init_req) begin
          state_d = INIT;
          cnt_d = '0;
        end else begin
          // on contention the requester not served last time wins
          rdy0 = req0_valid && (!req1_valid || last_q);
          rdy1 = req1_valid && (!req0_valid || !last_q);
          unique case (1'b1)
            rdy1: begin
              win_addr = req1_addr;
              win_data = req1_data;
            end
            default: begin
              win_addr = req0_addr;
              win_data = req0_data;
            end
          endcase
          if (rdy0 || rdy1) begin
            last_d = rdy1;
            if (!(PROTECT && win_addr == '0)) begin
              we_d = 1'b1;
              addr_d = win_addr;
              data_d = win_data;
              gid_d = rdy1;
            end
          end
        end
      end
    endcase
  end

  assign req0_ready = rdy0;
  assign req1_ready = rdy1;
  assign init_busy = (state_q == INIT);

endmodule
